sd_read_arbiter: RTL and testbench

- Shares one SD block-read engine (SPI reader with byte-wide FIFO push output) between two requesters, A and B.
- Each requester submits a descriptor: start byte address and block count. The arbiter grants round-robin, then issues one engine start per 512-byte block, advancing the address by BLOCK_BYTES each time.
- Engine output bytes are steered to the push port of the granted requester's FIFO.
- Sits between the SD reader and the per-consumer FIFOs (e.g. audio and frame buffers).

---
 rtl/sd_read_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_sd_read_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing one SD block-read engine between requesters A and B.
// Optional watchdog enabled by defining SDARB_TIMEOUT_EN.
`timescale 1ns/1ps
module sd_read_arbiter #(
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned ADDR_W         = 32,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [CNT_W-1:0]  count_a,
  input  logic [CNT_W-1:0]  count_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic              done_a,
  output logic              done_b,
  output logic              err_a,
  output logic              err_b,
  output logic              push_a,
  output logic              push_b,
  output logic [7:0]        push_data,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_busy,
  input  logic              eng_valid,
  input  logic [7:0]        eng_data,
  output logic              busy,
  output logic              owner
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  blk_left_q, blk_left_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic              mism_q, mism_d;
  logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic              done_a_q, done_a_d, done_b_q, done_b_d;
  logic              err_a_q, err_a_d, err_b_q, err_b_d;
  logic              push_a_q, push_a_d, push_b_q, push_b_d;
  logic [7:0]        push_data_q, push_data_d;
  logic              eng_start_q, eng_start_d;
  logic              grant_go, grant_sel, fail_now;
  logic              tmo_hit, tmo_err;

`ifdef SDARB_TIMEOUT_EN
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_err_q, tmo_err_d;

  // Loaded with 1 on ISSUE so the count includes the eng_start cycle and
  // the registered done pulse lands exactly TIMEOUT_CYCLES after eng_start.
  assign tmo_hit = ((state_q == S_WAIT) || (state_q == S_XFER)) &&
                   (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1);
  assign tmo_err = tmo_err_q;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
    if (state_q == S_ISSUE) begin
      tmo_cnt_d = 24'd1;
    end else if ((state_q == S_WAIT) || (state_q == S_XFER)) begin
      if (tmo_hit) tmo_err_d = 1'b1;
      else         tmo_cnt_d = tmo_cnt_q + 24'd1;
    end else if (state_q == S_DONE) begin
      tmo_err_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
  assign tmo_err    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cur_addr_d   = cur_addr_q;
    blk_left_d   = blk_left_q;
    byte_cnt_d   = byte_cnt_q;
    mism_d       = mism_q;
    push_data_d  = push_data_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    done_a_d     = 1'b0;
    done_b_d     = 1'b0;
    err_a_d      = 1'b0;
    err_b_d      = 1'b0;
    push_a_d     = 1'b0;
    push_b_d     = 1'b0;
    eng_start_d  = 1'b0;
    grant_go     = 1'b0;
    grant_sel    = 1'b0;
    fail_now     = mism_q | tmo_err;

    // Bytes are only steered once a block has been started; in IDLE they are dropped.
    if (eng_valid && (state_q != S_IDLE) && (state_q != S_ISSUE)) begin
      push_a_d    = ~owner_q;
      push_b_d    = owner_q;
      push_data_d = eng_data;
      byte_cnt_d  = byte_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_a && req_b) begin
          grant_go  = 1'b1;
          grant_sel = ~last_grant_q;
        end else if (req_a || req_b) begin
          grant_go  = 1'b1;
          grant_sel = req_b;
        end
        if (grant_go) begin
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          ack_a_d      = ~grant_sel;
          ack_b_d      = grant_sel;
          cur_addr_d   = grant_sel ? addr_b : addr_a;
          blk_left_d   = grant_sel ? count_b : count_a;
          state_d      = ((grant_sel ? count_b : count_a) == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start_d = 1'b1;
        byte_cnt_d  = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (tmo_hit)       state_d = S_DONE;
        else if (eng_busy) state_d = S_XFER;
      end
      S_XFER: begin
        if (tmo_hit)        state_d = S_DONE;
        else if (!eng_busy) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (byte_cnt_q != 16'(BLOCK_BYTES)) mism_d = 1'b1;
        cur_addr_d = cur_addr_q + ADDR_W'(BLOCK_BYTES);
        blk_left_d = blk_left_q - CNT_W'(1);
        state_d    = (blk_left_q == CNT_W'(1)) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done_a_d = ~owner_q;
        done_b_d = owner_q;
        err_a_d  = ~owner_q & fail_now;
        err_b_d  = owner_q & fail_now;
        mism_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cur_addr_q   <= '0;
      blk_left_q   <= '0;
      byte_cnt_q   <= '0;
      mism_q       <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      done_a_q     <= 1'b0;
      done_b_q     <= 1'b0;
      err_a_q      <= 1'b0;
      err_b_q      <= 1'b0;
      push_a_q     <= 1'b0;
      push_b_q     <= 1'b0;
      push_data_q  <= '0;
      eng_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cur_addr_q   <= cur_addr_d;
      blk_left_q   <= blk_left_d;
      byte_cnt_q   <= byte_cnt_d;
      mism_q       <= mism_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      done_a_q     <= done_a_d;
      done_b_q     <= done_b_d;
      err_a_q      <= err_a_d;
      err_b_q      <= err_b_d;
      push_a_q     <= push_a_d;
      push_b_q     <= push_b_d;
      push_data_q  <= push_data_d;
      eng_start_q  <= eng_start_d;
    end
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign err_a     = err_a_q;
  assign err_b     = err_b_q;
  assign push_a    = push_a_q;
  assign push_b    = push_b_q;
  assign push_data = push_data_q;
  assign eng_start = eng_start_q;
  assign eng_addr  = cur_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Scoreboard bench for sd_read_arbiter: directed requests, behavioural SD engine, event queue.
`timescale 1ns/1ps
module tb_sd_read_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] addr_a = '0, addr_b = '0;
  logic [15:0] count_a = '0, count_b = '0;
  logic        ack_a, ack_b, done_a, done_b, err_a, err_b, push_a, push_b;
  logic [7:0]  push_data;
  logic        eng_start;
  logic [31:0] eng_addr;
  logic        eng_busy = 1'b0, eng_valid = 1'b0;
  logic [7:0]  eng_data = '0;
  logic        busy, owner;

  always #5 clock = ~clock;

  sd_read_arbiter #(.BLOCK_BYTES(512), .CNT_W(16), .ADDR_W(32), .TIMEOUT_CYCLES(24'd1000)) dut (
    .clock(clock), .reset(reset), .req_a(req_a), .req_b(req_b),
    .addr_a(addr_a), .addr_b(addr_b), .count_a(count_a), .count_b(count_b),
    .ack_a(ack_a), .ack_b(ack_b), .done_a(done_a), .done_b(done_b),
    .err_a(err_a), .err_b(err_b), .push_a(push_a), .push_b(push_b),
    .push_data(push_data), .eng_start(eng_start), .eng_addr(eng_addr),
    .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_data(eng_data),
    .busy(busy), .owner(owner)
  );

  localparam int K_ACKA = 0, K_ACKB = 1, K_START = 2, K_DONEA = 3, K_DONEB = 4;

  typedef struct { int kind; logic [31:0] val; int dly; } ev_t;
  ev_t     expq[$];
  int      total = 0, bad = 0;
  int      pa = 0, pb = 0;
  longint  cyc = 0, last_ev_cyc = 0;
  logic [7:0] exp_byte = '0;
  int      nbytes = 512;
  bit      abort = 1'b0, eng_dead = 1'b0;

  task automatic expect_ev(input int kind, input logic [31:0] val, input int dly);
    ev_t e;
    e.kind = kind; e.val = val; e.dly = dly;
    expq.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [31:0] val);
    ev_t e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL event_unexpected got kind=%0d val=%0h at cycle %0d, wanted none", kind, val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.val != val || (e.dly >= 0 && (cyc - last_ev_cyc) != longint'(e.dly))) begin
        bad++;
        $display("FAIL event got kind=%0d val=%0h dly=%0d, wanted kind=%0d val=%0h dly=%0d",
                 kind, val, cyc - last_ev_cyc, e.kind, e.val, e.dly);
      end
    end
    last_ev_cyc = cyc;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h wanted=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outvec();
    return 64'({ack_a, ack_b, done_a, done_b, err_a, err_b, push_a, push_b,
                eng_start, busy, owner, push_data, eng_addr});
  endfunction

  // which: 0 ack_a, 1 ack_b, 2 done_a, 3 done_b
  task automatic wait_for(input int which, input int limit, input string nm);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clock);
      n++;
      case (which)
        0: hit = ack_a;
        1: hit = ack_b;
        2: hit = done_a;
        default: hit = done_b;
      endcase
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL wait_%s got=no_event_after_%0d wanted=event", nm, n);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      cyc++;
      if (ack_a) check_ev(K_ACKA, 32'd0);
      if (ack_b) check_ev(K_ACKB, 32'd0);
      if (eng_start) begin
        check_ev(K_START, eng_addr);
        exp_byte = 8'd0;
      end
      if (done_a) check_ev(K_DONEA, {31'd0, err_a});
      if (done_b) check_ev(K_DONEB, {31'd0, err_b});
      if ((err_a && !done_a) || (err_b && !done_b)) begin
        total++; bad++;
        $display("FAIL err_without_done got err_a=%0b err_b=%0b wanted done with err", err_a, err_b);
      end
      if (push_a && push_b) begin
        total++; bad++;
        $display("FAIL push_both got=11 wanted one side");
      end
      if (push_a || push_b) begin
        if (push_a) pa++;
        if (push_b) pb++;
        total++;
        if (push_data !== exp_byte) begin
          bad++;
          $display("FAIL push_data got=%0h wanted=%0h", push_data, exp_byte);
        end
        exp_byte = exp_byte + 8'd1;
      end
    end
  endtask

  task automatic engine();
    int stray;
    forever begin
      @(negedge clock);
      if (eng_start && !eng_dead) begin
        @(posedge clock); #1;
        eng_busy = 1'b1;
        stray = 0;
        for (int i = 0; i < nbytes; i++) begin
          if (abort) begin
            stray++;
            if (stray > 4) break;
          end
          eng_valid = 1'b1;
          eng_data  = 8'(i);
          @(posedge clock); #1;
        end
        eng_valid = 1'b0;
        eng_busy  = 1'b0;
      end
    end
  endtask

  initial begin
    int pa0, pb0, pa1, pb1, n;
    fork
      monitor();
      engine();
    join_none
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", outvec(), 64'd0);
    reset = 1'b0;

    // Tie from reset with both held: A, B, A
    pa0 = pa; pb0 = pb;
    expect_ev(K_ACKA, 0, -1); expect_ev(K_START, 32'h0, 1); expect_ev(K_DONEA, 0, -1);
    expect_ev(K_ACKB, 0, 1);  expect_ev(K_START, 32'h8000_0000, 1); expect_ev(K_DONEB, 0, -1);
    expect_ev(K_ACKA, 0, 1);  expect_ev(K_START, 32'h0, 1); expect_ev(K_DONEA, 0, -1);
    addr_a = 32'h0; count_a = 16'd1; addr_b = 32'h8000_0000; count_b = 16'd1;
    req_a = 1'b1; req_b = 1'b1;
    wait_for(0, 20, "tie_ack_a1");
    wait_for(1, 2000, "tie_ack_b");
    wait_for(0, 2000, "tie_ack_a2");
    req_a = 1'b0; req_b = 1'b0;
    wait_for(2, 2000, "tie_done_a2");
    repeat (2) @(negedge clock);
    chk("tie_push_a", 64'(pa - pa0), 64'd1024);
    chk("tie_push_b", 64'(pb - pb0), 64'd512);

    // Single requester, two blocks
    pa0 = pa; pb0 = pb;
    expect_ev(K_ACKA, 0, -1); expect_ev(K_START, 32'h400, 1);
    expect_ev(K_START, 32'h600, -1); expect_ev(K_DONEA, 0, -1);
    addr_a = 32'h400; count_a = 16'd2; req_a = 1'b1;
    wait_for(0, 20, "single_ack");
    req_a = 1'b0;
    wait_for(2, 3000, "single_done");
    repeat (2) @(negedge clock);
    chk("single_push_a", 64'(pa - pa0), 64'd1024);
    chk("single_push_b", 64'(pb - pb0), 64'd0);

    // Zero block count
    expect_ev(K_ACKB, 0, -1); expect_ev(K_DONEB, 0, 1);
    addr_b = 32'h1234; count_b = 16'd0; req_b = 1'b1;
    wait_for(1, 20, "zero_ack");
    req_b = 1'b0;
    wait_for(3, 20, "zero_done");

    // Short block of 511 bytes
    pa0 = pa; nbytes = 511;
    expect_ev(K_ACKA, 0, -1); expect_ev(K_START, 32'h2000, 1); expect_ev(K_DONEA, 1, -1);
    addr_a = 32'h2000; count_a = 16'd1; req_a = 1'b1;
    wait_for(0, 20, "short_ack");
    req_a = 1'b0;
    wait_for(2, 2000, "short_done");
    repeat (2) @(negedge clock);
    chk("short_push_a", 64'(pa - pa0), 64'd511);
    nbytes = 512;

    // Reset in the middle of block 1
    pa0 = pa;
    expect_ev(K_ACKA, 0, -1); expect_ev(K_START, 32'h1000, 1);
    addr_a = 32'h1000; count_a = 16'd2; req_a = 1'b1;
    wait_for(0, 20, "rst_ack");
    req_a = 1'b0;
    n = 0;
    while (pa < pa0 + 100 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("rst_reach_100", 64'(pa - pa0 >= 100), 64'd1);
    reset = 1'b1; abort = 1'b1;
    @(negedge clock);
    chk("rst_mid_outputs", outvec(), 64'd0);
    reset = 1'b0;
    pa1 = pa; pb1 = pb;
    repeat (12) @(negedge clock);
    chk("rst_stray_push", 64'((pa - pa1) + (pb - pb1)), 64'd0);
    chk("rst_idle_busy", 64'(busy), 64'd0);
    abort = 1'b0;
    pa0 = pa; pb0 = pb;
    expect_ev(K_ACKB, 0, -1); expect_ev(K_START, 32'h4000, 1); expect_ev(K_DONEB, 0, -1);
    addr_b = 32'h4000; count_b = 16'd1; req_b = 1'b1;
    wait_for(1, 20, "after_rst_ack_b");
    req_b = 1'b0;
    wait_for(3, 2000, "after_rst_done_b");
    repeat (2) @(negedge clock);
    chk("after_rst_push_b", 64'(pb - pb0), 64'd512);
    chk("after_rst_push_a", 64'(pa - pa0), 64'd0);

`ifdef SDARB_TIMEOUT_EN
    // Engine never answers: watchdog ends the transfer 1000 cycles after eng_start
    eng_dead = 1'b1;
    expect_ev(K_ACKA, 0, -1); expect_ev(K_START, 32'h3000, 1); expect_ev(K_DONEA, 1, 1000);
    addr_a = 32'h3000; count_a = 16'd3; req_a = 1'b1;
    wait_for(0, 20, "tmo_ack");
    req_a = 1'b0;
    wait_for(2, 1500, "tmo_done");
    chk("tmo_idle", 64'(busy), 64'd0);
    eng_dead = 1'b0;
`endif

    repeat (5) @(negedge clock);
    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
